// File: rtl/mdio_master.sv
// Clause-22 MDIO management master.
// Serialises one read or write frame per accepted command onto the MDC/MDIO
// pads, samples read data on the MDC rising edges and reports completion.
//
// Command handshake: a command transfers on the rising clk edge where
// cmd_valid && cmd_ready are both 1. cmd_ready is 1 only while the block is
// idle, so no command is queued while a frame is in progress. cmd_valid may
// be asserted at any time and the cmd_* fields are only sampled at the transfer.
module mdio_master #(
    parameter int unsigned MDC_DIV = 4,
    parameter int unsigned PRE_LEN = 32
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_rd,
    input  logic [4:0]  cmd_phyad,
    input  logic [4:0]  cmd_regad,
    input  logic [15:0] cmd_wdata,
    output logic        mdc,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic        mdio_i,
    output logic        done,
    output logic [15:0] rd_data,
    output logic        ta_err,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    // Bit positions inside the frame, counted from the first preamble bit.
    localparam logic [7:0] DIV_LAST   = 8'(MDC_DIV - 1);
    localparam logic [6:0] STOP_FIRST = 7'(PRE_LEN);
    localparam logic [6:0] ADDR_FIRST = 7'(PRE_LEN + 4);
    localparam logic [6:0] TA_FIRST   = 7'(PRE_LEN + 14);
    localparam logic [6:0] TA_SECOND  = 7'(PRE_LEN + 15);
    localparam logic [6:0] DATA_FIRST = 7'(PRE_LEN + 16);
    localparam logic [6:0] LAST_BIT   = 7'(PRE_LEN + 31);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE  = 3'd1,
        S_STOP = 3'd2,
        S_ADDR = 3'd3,
        S_TA   = 3'd4,
        S_DATA = 3'd5
    } state_t;

    // Frame field that a given bit position belongs to.
    function automatic state_t state_of(input logic [6:0] b);
        state_t s;
        if (b < STOP_FIRST)      s = S_PRE;
        else if (b < ADDR_FIRST) s = S_STOP;
        else if (b < TA_FIRST)   s = S_ADDR;
        else if (b < DATA_FIRST) s = S_TA;
        else                     s = S_DATA;
        return s;
    endfunction

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [6:0]  bit_q, bit_d;
    logic [31:0] sh_q, sh_d;
    logic        rd_q, rd_d;
    logic        mdc_q, mdc_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_oe_q, mdio_oe_d;
    logic        ready_q, ready_d;
    logic        done_q, done_d;
    logic [15:0] rd_data_q, rd_data_d;
    logic        ta_err_q, ta_err_d;
    logic [15:0] rd_sh_q, rd_sh_d;
    logic        ta_smp_q, ta_smp_d;
    logic [6:0]  nb;

    // Next-state logic: accept, MDC phase timing, bit shifting and read sampling.
    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        bit_d     = bit_q;
        sh_d      = sh_q;
        rd_d      = rd_q;
        mdc_d     = mdc_q;
        mdio_o_d  = mdio_o_q;
        mdio_oe_d = mdio_oe_q;
        ready_d   = ready_q;
        done_d    = 1'b0;
        rd_data_d = rd_data_q;
        ta_err_d  = ta_err_q;
        rd_sh_d   = rd_sh_q;
        ta_smp_d  = ta_smp_q;
        nb        = bit_q + 7'd1;

        if (state_q == S_IDLE) begin
            mdc_d     = 1'b0;
            mdio_o_d  = 1'b1;
            mdio_oe_d = 1'b0;
            ready_d   = 1'b1;
            if (cmd_valid && ready_q) begin
                // Accept edge is also the start of the first low phase.
                state_d   = S_PRE;
                ready_d   = 1'b0;
                rd_d      = cmd_rd;
                sh_d      = {2'b01, (cmd_rd ? 2'b10 : 2'b01), cmd_phyad,
                             cmd_regad, 2'b10, cmd_wdata};
                bit_d     = 7'd0;
                div_d     = 8'd0;
                mdio_o_d  = 1'b1;
                mdio_oe_d = 1'b1;
            end
        end else if (div_q == DIV_LAST) begin
            div_d = 8'd0;
            if (!mdc_q) begin
                // Low phase ends: MDC rises, which is the read sampling point.
                mdc_d = 1'b1;
                if (rd_q && bit_q == TA_SECOND) begin
                    ta_smp_d = mdio_i;
                end else if (rd_q && bit_q >= DATA_FIRST) begin
                    rd_sh_d = {rd_sh_q[14:0], mdio_i};
                end
            end else begin
                // High phase ends: bit period over.
                mdc_d = 1'b0;
                if (bit_q == LAST_BIT) begin
                    state_d   = S_IDLE;
                    ready_d   = 1'b1;
                    done_d    = 1'b1;
                    mdio_o_d  = 1'b1;
                    mdio_oe_d = 1'b0;
                    if (rd_q) begin
                        rd_data_d = rd_sh_q;
                        ta_err_d  = ta_smp_q;
                    end else begin
                        ta_err_d  = 1'b0;
                    end
                end else begin
                    bit_d     = nb;
                    state_d   = state_of(nb);
                    mdio_oe_d = !(rd_q && nb >= TA_FIRST);
                    if (nb >= STOP_FIRST) begin
                        mdio_o_d = sh_q[31];
                        sh_d     = {sh_q[30:0], 1'b0};
                    end else begin
                        mdio_o_d = 1'b1;
                    end
                end
            end
        end else begin
            div_d = div_q + 8'd1;
        end
    end

    // State and output registers; reset aborts any frame in progress.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_IDLE;
            div_q     <= 8'd0;
            bit_q     <= 7'd0;
            sh_q      <= 32'd0;
            rd_q      <= 1'b0;
            mdc_q     <= 1'b0;
            mdio_o_q  <= 1'b1;
            mdio_oe_q <= 1'b0;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            rd_data_q <= 16'h0000;
            ta_err_q  <= 1'b0;
            rd_sh_q   <= 16'h0000;
            ta_smp_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            bit_q     <= bit_d;
            sh_q      <= sh_d;
            rd_q      <= rd_d;
            mdc_q     <= mdc_d;
            mdio_o_q  <= mdio_o_d;
            mdio_oe_q <= mdio_oe_d;
            ready_q   <= ready_d;
            done_q    <= done_d;
            rd_data_q <= rd_data_d;
            ta_err_q  <= ta_err_d;
            rd_sh_q   <= rd_sh_d;
            ta_smp_q  <= ta_smp_d;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = (state_q != S_IDLE);
    assign mdc       = mdc_q;
    assign mdio_o    = mdio_o_q;
    assign mdio_oe   = mdio_oe_q;
    assign done      = done_q;
    assign rd_data   = rd_data_q;
    assign ta_err    = ta_err_q;
    assign dbg_state = state_q;

endmodule
